// File: rtl/sequenciador_rodadas_pkg.sv
// Shared constants for the memory-game round sequencer: state codes, configuracao bit
// positions and display width. TIMEOUT_JOGADA_EN selects whether the per-jogada timeout exists.
package sequenciador_rodadas_pkg;

    localparam int LARGURA_DISPLAY = 4;

    localparam int CFG_MODO    = 0;
    localparam int CFG_TIMEOUT = 1;

    localparam logic [3:0] EST_INICIAL         = 4'b0000;
    localparam logic [3:0] EST_PREPARACAO      = 4'b0001;
    localparam logic [3:0] EST_INICIA_RODADA   = 4'b0010;
    localparam logic [3:0] EST_MOSTRA_LED      = 4'b0011;
    localparam logic [3:0] EST_PROXIMO_LED     = 4'b0100;
    localparam logic [3:0] EST_MOSTRA_APAGADO  = 4'b0101;
    localparam logic [3:0] EST_ZERA_ENDERECO   = 4'b0110;
    localparam logic [3:0] EST_ESPERA_JOGADA   = 4'b0111;
    localparam logic [3:0] EST_REGISTRA        = 4'b1000;
    localparam logic [3:0] EST_COMPARACAO      = 4'b1001;
    localparam logic [3:0] EST_PROXIMA_JOGADA  = 4'b1010;
    localparam logic [3:0] EST_PREPARA_ESCRITA = 4'b1011;
    localparam logic [3:0] EST_FIM_GANHOU      = 4'b1100;
    localparam logic [3:0] EST_ESPERA_NOVA     = 4'b1101;
    localparam logic [3:0] EST_FIM_PERDEU      = 4'b1110;
    localparam logic [3:0] EST_FIM_TIMEOUT     = 4'b1111;

`ifdef TIMEOUT_JOGADA_EN
    localparam logic TIMEOUT_PRESENTE = 1'b1;
`else
    localparam logic TIMEOUT_PRESENTE = 1'b0;
`endif

    function automatic logic estado_final(input logic [3:0] estado);
        return (estado == EST_FIM_GANHOU) || (estado == EST_FIM_PERDEU) ||
               (estado == EST_FIM_TIMEOUT);
    endfunction

endpackage

// File: rtl/sequenciador_rodadas_if.sv
// Game-side bus of the round sequencer: top-level controls, pattern RAM port and display.
// The slave modport is the sequencer's view; master is the surrounding system's view.
interface sequenciador_rodadas_if #(
    parameter int ADDR_W = 4
);
    import sequenciador_rodadas_pkg::*;

    logic                       jogar;
    logic [1:0]                 configuracao;
    logic [LARGURA_DISPLAY-1:0] botoes;
    logic [LARGURA_DISPLAY-1:0] mem_dado;
    logic [ADDR_W-1:0]          mem_endereco;
    logic                       mem_we;
    logic [LARGURA_DISPLAY-1:0] mem_escrita;
    logic [LARGURA_DISPLAY-1:0] leds;
    logic                       ganhou;
    logic                       perdeu;
    logic                       timeout;
    logic                       pronto;
    logic [3:0]                 db_estado;

    modport master (
        output jogar, configuracao, botoes, mem_dado,
        input  mem_endereco, mem_we, mem_escrita, leds, ganhou, perdeu, timeout, pronto,
               db_estado
    );

    modport slave (
        input  jogar, configuracao, botoes, mem_dado,
        output mem_endereco, mem_we, mem_escrita, leds, ganhou, perdeu, timeout, pronto,
               db_estado
    );

endinterface

// File: rtl/sequenciador_rodadas_detector_jogada.sv
// Turns the synchronised one-hot buttons into a single-cycle jogada_feita pulse on the
// rising edge of "any button pressed"; a held button yields exactly one pulse.
module sequenciador_rodadas_detector_jogada
    import sequenciador_rodadas_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [LARGURA_DISPLAY-1:0] i_botoes,
    output logic                       o_jogada_feita
);

    logic w_algum;
    logic r_algum_ant;

    assign w_algum = |i_botoes;

    // Remembers whether any button was down in the previous cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_algum_ant <= 1'b0;
        end else begin
            r_algum_ant <= w_algum;
        end
    end

    assign o_jogada_feita = w_algum & ~r_algum_ant;

endmodule

// File: rtl/sequenciador_rodadas.sv
// Memory-game control unit: shows the stored pattern, checks each jogada against the RAM and
// appends one player-entered element per round. TIMEOUT_JOGADA_EN adds the per-jogada timeout.
module sequenciador_rodadas
    import sequenciador_rodadas_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int N_RODADAS_FULL = 16,
    parameter int N_RODADAS_DEMO = 4,
    parameter int TEMPO_LED      = 1000,
    parameter int TEMPO_APAGADO  = 500,
    parameter int TEMPO_TIMEOUT  = 5000
) (
    input  logic                 clock,
    input  logic                 reset,
    sequenciador_rodadas_if.slave bus
);

    localparam int TEMPO_EXIB = (TEMPO_LED > TEMPO_APAGADO) ? TEMPO_LED : TEMPO_APAGADO;
    localparam int TEMPO_MAX  = (TEMPO_TIMEOUT > TEMPO_EXIB) ? TEMPO_TIMEOUT : TEMPO_EXIB;
    localparam int CONT_W     = $clog2(TEMPO_MAX + 1);

    localparam logic [CONT_W-1:0] FIM_LED     = CONT_W'(TEMPO_LED - 1);
    localparam logic [CONT_W-1:0] FIM_APAGADO = CONT_W'(TEMPO_APAGADO - 1);
    localparam logic [CONT_W-1:0] FIM_TIMEOUT = CONT_W'(TEMPO_TIMEOUT - 1);

    logic [3:0]                 r_estado;
    logic [CONT_W-1:0]          r_cont;
    logic [ADDR_W-1:0]          r_rodada;
    logic [ADDR_W-1:0]          r_endereco;
    logic [LARGURA_DISPLAY-1:0] r_jogada;
    logic                       r_modo;
    logic                       r_timeout_hab;
    logic                       r_mem_we;
    logic [LARGURA_DISPLAY-1:0] r_mem_escrita;

    logic [3:0]        w_prox;
    logic              w_conta;
    logic              w_jogada_feita;
    logic              w_expira;
    logic [ADDR_W-1:0] w_ultima;

    sequenciador_rodadas_detector_jogada u_detector (
        .clock          (clock),
        .reset          (reset),
        .i_botoes       (bus.botoes),
        .o_jogada_feita (w_jogada_feita)
    );

    assign w_ultima = r_modo ? ADDR_W'(N_RODADAS_DEMO - 1) : ADDR_W'(N_RODADAS_FULL - 1);
    assign w_expira = TIMEOUT_PRESENTE && r_timeout_hab && (r_cont == FIM_TIMEOUT);

    // Selects which states advance the shared cycle counter.
    always_comb begin
        w_conta = 1'b0;
        case (r_estado)
            EST_MOSTRA_LED, EST_MOSTRA_APAGADO: w_conta = 1'b1;
`ifdef TIMEOUT_JOGADA_EN
            EST_ESPERA_JOGADA, EST_ESPERA_NOVA: w_conta = 1'b1;
`endif
            default:                            w_conta = 1'b0;
        endcase
    end

    // Next-state logic; a jogada in the same cycle as timer expiry takes precedence.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            EST_INICIAL:         w_prox = bus.jogar ? EST_PREPARACAO : EST_INICIAL;
            EST_PREPARACAO:      w_prox = EST_INICIA_RODADA;
            EST_INICIA_RODADA:   w_prox = EST_MOSTRA_LED;
            EST_MOSTRA_LED:      w_prox = (r_cont == FIM_LED) ? EST_MOSTRA_APAGADO : EST_MOSTRA_LED;
            EST_MOSTRA_APAGADO: begin
                if (r_cont != FIM_APAGADO) begin
                    w_prox = EST_MOSTRA_APAGADO;
                end else if (r_endereco == r_rodada) begin
                    w_prox = EST_ZERA_ENDERECO;
                end else begin
                    w_prox = EST_PROXIMO_LED;
                end
            end
            EST_PROXIMO_LED:     w_prox = EST_MOSTRA_LED;
            EST_ZERA_ENDERECO:   w_prox = EST_ESPERA_JOGADA;
            EST_ESPERA_JOGADA, EST_ESPERA_NOVA: begin
                if (w_jogada_feita) begin
                    w_prox = (r_estado == EST_ESPERA_JOGADA) ? EST_REGISTRA : EST_INICIA_RODADA;
                end else if (w_expira) begin
                    w_prox = EST_FIM_TIMEOUT;
                end else begin
                    w_prox = r_estado;
                end
            end
            EST_REGISTRA:        w_prox = EST_COMPARACAO;
            EST_COMPARACAO: begin
                if (r_jogada != bus.mem_dado) begin
                    w_prox = EST_FIM_PERDEU;
                end else if (r_endereco != r_rodada) begin
                    w_prox = EST_PROXIMA_JOGADA;
                end else if (r_rodada == w_ultima) begin
                    w_prox = EST_FIM_GANHOU;
                end else begin
                    w_prox = EST_PREPARA_ESCRITA;
                end
            end
            EST_PROXIMA_JOGADA:  w_prox = EST_ESPERA_JOGADA;
            EST_PREPARA_ESCRITA: w_prox = EST_ESPERA_NOVA;
            EST_FIM_GANHOU, EST_FIM_PERDEU, EST_FIM_TIMEOUT:
                                 w_prox = bus.jogar ? EST_PREPARACAO : r_estado;
            default:             w_prox = EST_INICIAL;
        endcase
    end

    // State, counter, round/address bookkeeping and the registered write port.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado      <= EST_INICIAL;
            r_cont        <= '0;
            r_rodada      <= '0;
            r_endereco    <= '0;
            r_jogada      <= '0;
            r_modo        <= 1'b0;
            r_timeout_hab <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_escrita <= '0;
        end else begin
            r_estado <= w_prox;
            r_mem_we <= 1'b0;
            if (w_prox != r_estado) begin
                r_cont <= '0;
            end else if (w_conta) begin
                r_cont <= r_cont + CONT_W'(1);
            end
            case (r_estado)
                EST_PREPARACAO: begin
                    r_rodada      <= '0;
                    r_endereco    <= '0;
                    r_jogada      <= '0;
                    r_mem_escrita <= '0;
                    r_modo        <= bus.configuracao[CFG_MODO];
                    r_timeout_hab <= bus.configuracao[CFG_TIMEOUT];
                end
                EST_INICIA_RODADA, EST_ZERA_ENDERECO: r_endereco <= '0;
                EST_PROXIMO_LED, EST_PROXIMA_JOGADA:  r_endereco <= r_endereco + ADDR_W'(1);
                EST_REGISTRA:                         r_jogada   <= bus.botoes;
                EST_PREPARA_ESCRITA:                  r_endereco <= r_rodada + ADDR_W'(1);
                EST_ESPERA_NOVA: begin
                    if (w_jogada_feita) begin
                        r_mem_we      <= 1'b1;
                        r_mem_escrita <= bus.botoes;
                        r_rodada      <= r_rodada + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.leds         = (r_estado == EST_MOSTRA_LED) ? bus.mem_dado : '0;
    assign bus.ganhou       = (r_estado == EST_FIM_GANHOU);
    assign bus.perdeu       = (r_estado == EST_FIM_PERDEU);
`ifdef TIMEOUT_JOGADA_EN
    assign bus.timeout      = (r_estado == EST_FIM_TIMEOUT);
`else
    assign bus.timeout      = 1'b0;
`endif
    assign bus.pronto       = estado_final(r_estado);
    assign bus.db_estado    = r_estado;
    assign bus.mem_endereco = r_endereco;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_escrita  = r_mem_escrita;

endmodule

// File: tb/tb_sequenciador_rodadas.sv
// Self-checking bench for sequenciador_rodadas: plays randomized games against a queue-based
// model of the pattern and checks display timing, write-back, win/loss/timeout and restart.
module tb_sequenciador_rodadas;

    localparam int ADDR_W = 4;
    localparam int T_LED  = 12;
    localparam int T_APAG = 6;
    localparam int T_TO   = 40;
    localparam int N_DEMO = 4;
    localparam int N_FULL = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] ram [0:15];
    logic       carga_en;
    logic [3:0] carga_addr;
    logic [3:0] carga_dado;
    logic [3:0] patt [$];
    int         n_tests = 0;
    int         n_fail  = 0;

    sequenciador_rodadas_if #(.ADDR_W(ADDR_W)) bus ();

    sequenciador_rodadas #(
        .ADDR_W(ADDR_W), .N_RODADAS_FULL(N_FULL), .N_RODADAS_DEMO(N_DEMO),
        .TEMPO_LED(T_LED), .TEMPO_APAGADO(T_APAG), .TEMPO_TIMEOUT(T_TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign bus.mem_dado = ram[bus.mem_endereco];

    always @(posedge clock) begin
        if (bus.mem_we) ram[bus.mem_endereco] <= bus.mem_escrita;
        else if (carga_en) ram[carga_addr] <= carga_dado;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] onehot_rand();
        logic [3:0] v;
        v = 4'b0001;
        v = v << $urandom_range(3, 0);
        return v;
    endfunction

    task automatic load_ram(input logic [3:0] a, input logic [3:0] d);
        carga_addr = a;
        carga_dado = d;
        carga_en   = 1'b1;
        tick();
        carga_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.jogar = 1'b0;
        bus.botoes = 4'b0000;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_state(input logic [3:0] code, input int budget, output bit ok);
        int k;
        k  = 0;
        ok = (bus.db_estado === code);
        while (!ok && k < budget) begin
            tick();
            k++;
            ok = (bus.db_estado === code);
        end
    endtask

    task automatic start_game(input logic [1:0] cfg);
        bus.configuracao = cfg;
        bus.jogar = 1'b1;
        tick();
        bus.jogar = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        bus.botoes = b;
        repeat (3) tick();
        bus.botoes = 4'b0000;
        repeat (2) tick();
    endtask

    // Checks one round of display: n elements, each lit T_LED cycles then dark T_APAG cycles.
    task automatic observe_display(input int n);
        bit ok;
        int cnt;
        int bad;
        logic [3:0] nxt;
        for (int i = 0; i < n; i++) begin
            wait_state(4'b0011, 100, ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL disp_enter[%0d]: state %b, required 0011", i, bus.db_estado);
            end
            cnt = 0;
            bad = 0;
            while (bus.db_estado === 4'b0011 && cnt < 1000) begin
                if (bus.leds !== patt[i] || bus.mem_endereco !== ADDR_W'(i)) bad++;
                cnt++;
                tick();
            end
            n_tests++;
            if (cnt != T_LED || bad != 0) begin
                n_fail++;
                $display("FAIL disp_led[%0d]: %0d cycles (%0d bad), required %0d cycles of %b",
                         i, cnt, bad, T_LED, patt[i]);
            end
            cnt = 0;
            bad = 0;
            while (bus.db_estado === 4'b0101 && cnt < 1000) begin
                if (bus.leds !== 4'b0000) bad++;
                cnt++;
                tick();
            end
            n_tests++;
            if (cnt != T_APAG || bad != 0) begin
                n_fail++;
                $display("FAIL disp_dark[%0d]: %0d cycles (%0d lit), required %0d", i, cnt, bad, T_APAG);
            end
            nxt = (i == n - 1) ? 4'b0110 : 4'b0100;
            n_tests++;
            if (bus.db_estado !== nxt) begin
                n_fail++;
                $display("FAIL disp_next[%0d]: state %b, required %b", i, bus.db_estado, nxt);
            end
        end
    endtask

    task automatic enter_upto(input int cnt);
        bit ok;
        for (int i = 0; i < cnt; i++) begin
            wait_state(4'b0111, 50, ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL wait_jogada[%0d]: state %b, required 0111", i, bus.db_estado);
            end
            press(patt[i]);
        end
    endtask

    // Enters a new random element in 1101 and checks the write pulse and RAM contents.
    task automatic write_back(input int r);
        bit ok;
        logic [3:0] b;
        wait_state(4'b1101, 20, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wb_state[%0d]: state %b, required 1101", r, bus.db_estado);
        end
        b = onehot_rand();
        bus.botoes = b;
        tick();
        n_tests++;
        if (bus.mem_we !== 1'b1 || bus.mem_endereco !== ADDR_W'(r + 1) ||
            bus.mem_escrita !== b || bus.db_estado !== 4'b0010) begin
            n_fail++;
            $display("FAIL wb_pulse[%0d]: we=%b addr=%0d data=%b st=%b, required 1/%0d/%b/0010",
                     r, bus.mem_we, bus.mem_endereco, bus.mem_escrita, bus.db_estado, r + 1, b);
        end
        tick();
        n_tests++;
        if (bus.mem_we !== 1'b0 || ram[r + 1] !== b) begin
            n_fail++;
            $display("FAIL wb_after[%0d]: we=%b ram=%b, required 0/%b", r, bus.mem_we, ram[r + 1], b);
        end
        bus.botoes = 4'b0000;
        patt.push_back(b);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.jogar = 1'b1;
        bus.configuracao = 2'b11;
        bus.botoes = onehot_rand();
        tick();
        tick();
        n_tests++;
        if (bus.db_estado !== 4'b0000 || bus.leds !== 4'b0000 || bus.mem_endereco !== '0) begin
            n_fail++;
            $display("FAIL reset_state: st=%b leds=%b addr=%0d, required 0000/0000/0",
                     bus.db_estado, bus.leds, bus.mem_endereco);
        end
        n_tests++;
        if ({bus.ganhou, bus.perdeu, bus.timeout, bus.pronto, bus.mem_we} !== 5'b00000 ||
            bus.mem_escrita !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: g/p/t/pr/we=%b%b%b%b%b escrita=%b, required 00000/0000",
                     bus.ganhou, bus.perdeu, bus.timeout, bus.pronto, bus.mem_we, bus.mem_escrita);
        end
        bus.jogar = 1'b0;
        bus.botoes = 4'b0000;
        for (int a = 0; a < 16; a++) load_ram(4'(a), 4'b0001 << (a % 4));
        reset = 1'b1;
        tick();
        n_tests++;
        if (bus.db_estado !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_no_jogar: state %b, required 0000", bus.db_estado);
        end
    endtask

    task automatic test_demo_win();
        bit ok;
        do_reset();
        load_ram(4'd0, 4'b0001);
        load_ram(4'd1, 4'b0010);
        load_ram(4'd2, 4'b0100);
        load_ram(4'd3, 4'b1000);
        patt.delete();
        patt.push_back(4'b0001);
        start_game(2'b01);
        for (int r = 0; r < N_DEMO; r++) begin
            observe_display(r + 1);
            if (r == 1) bus.configuracao = 2'b00;
            enter_upto(r + 1);
            if (r < N_DEMO - 1) write_back(r);
        end
        wait_state(4'b1100, 20, ok);
        n_tests++;
        if (!ok || bus.ganhou !== 1'b1 || bus.pronto !== 1'b1 || bus.perdeu !== 1'b0 ||
            bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL demo_win: st=%b ganhou=%b pronto=%b perdeu=%b, required 1100/1/1/0",
                     bus.db_estado, bus.ganhou, bus.pronto, bus.perdeu);
        end
    endtask

    // Loses with a wrong jogada, restarting each game from the end state (no reset between).
    task automatic test_random_wrong();
        int k;
        int j;
        int n;
        bit ok;
        logic [3:0] wrong;
        do_reset();
        for (int it = 0; it < 4; it++) begin
            patt.delete();
            if (it == 0) patt.push_back(4'b0001);
            else patt.push_back(onehot_rand());
            load_ram(4'd0, patt[0]);
            k = (it == 0) ? 0 : $urandom_range(3, 1);
            j = (it == 0) ? 0 : $urandom_range(k, 0);
            start_game((it == 0) ? 2'b01 : 2'b00);
            n_tests++;
            if (bus.db_estado !== 4'b0001 || bus.perdeu !== 1'b0 || bus.pronto !== 1'b0) begin
                n_fail++;
                $display("FAIL restart_prep[%0d]: st=%b perdeu=%b pronto=%b, required 0001/0/0",
                         it, bus.db_estado, bus.perdeu, bus.pronto);
            end
            tick();
            n_tests++;
            if (bus.db_estado !== 4'b0010 || bus.mem_endereco !== '0) begin
                n_fail++;
                $display("FAIL restart_inicia[%0d]: st=%b addr=%0d, required 0010/0",
                         it, bus.db_estado, bus.mem_endereco);
            end
            for (int r = 0; r < k; r++) begin
                observe_display(r + 1);
                enter_upto(r + 1);
                write_back(r);
            end
            observe_display(k + 1);
            enter_upto(j);
            wait_state(4'b0111, 50, ok);
            wrong = (it == 0) ? 4'b1000 : {patt[j][2:0], patt[j][3]};
            bus.botoes = wrong;
            n = 0;
            while (bus.db_estado !== 4'b1110 && n < 6) begin
                tick();
                n++;
            end
            n_tests++;
            if (!ok || bus.db_estado !== 4'b1110 || n > 3 || bus.perdeu !== 1'b1 ||
                bus.pronto !== 1'b1 || bus.ganhou !== 1'b0) begin
                n_fail++;
                $display("FAIL wrong[%0d]: st=%b after %0d cycles perdeu=%b pronto=%b, required 1110 in <=3",
                         it, bus.db_estado, n, bus.perdeu, bus.pronto);
            end
            bus.botoes = 4'b0000;
            tick();
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        do_reset();
        patt.delete();
        patt.push_back(onehot_rand());
        load_ram(4'd0, patt[0]);
        start_game(2'b11);
        observe_display(1);
        bus.configuracao = 2'b00;
        wait_state(4'b0111, 10, ok);
`ifdef TIMEOUT_JOGADA_EN
        n = 0;
        while (bus.db_estado !== 4'b1111 && n < T_TO + 10) begin
            tick();
            n++;
        end
        n_tests++;
        if (!ok || n != T_TO || bus.timeout !== 1'b1 || bus.pronto !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_0111: 1111 after %0d cycles timeout=%b pronto=%b, required %0d/1/1",
                     n, bus.timeout, bus.pronto, T_TO);
        end
        start_game(2'b11);
        observe_display(1);
        wait_state(4'b0111, 10, ok);
        repeat (T_TO - 1) tick();
        bus.botoes = patt[0];
        tick();
        n_tests++;
        if (bus.db_estado !== 4'b1000) begin
            n_fail++;
            $display("FAIL timeout_tie: state %b, required 1000", bus.db_estado);
        end
        tick();
        tick();
        bus.botoes = 4'b0000;
        wait_state(4'b1101, 10, ok);
        n = 0;
        while (bus.db_estado !== 4'b1111 && n < T_TO + 10) begin
            tick();
            n++;
        end
        n_tests++;
        if (!ok || n != T_TO || bus.timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_1101: 1111 after %0d cycles timeout=%b, required %0d/1",
                     n, bus.timeout, T_TO);
        end
`else
        repeat (3 * T_TO) tick();
        n = 0;
        n_tests++;
        if (!ok || bus.db_estado !== 4'b0111 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_build: st=%b timeout=%b, required 0111/0",
                     bus.db_estado, bus.timeout);
        end
`endif
    endtask

    task automatic test_no_timeout_and_reset();
        bit ok;
        logic [3:0] old1;
        do_reset();
        patt.delete();
        patt.push_back(onehot_rand());
        load_ram(4'd0, patt[0]);
        start_game(2'b00);
        observe_display(1);
        wait_state(4'b0111, 10, ok);
        repeat (25000) tick();
        n_tests++;
        if (!ok || bus.db_estado !== 4'b0111 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_0111: st=%b timeout=%b, required 0111/0", bus.db_estado, bus.timeout);
        end
        bus.botoes = patt[0];
        repeat (10) tick();
        n_tests++;
        if (bus.db_estado !== 4'b1101 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL held_button: st=%b we=%b, required 1101/0", bus.db_estado, bus.mem_we);
        end
        bus.botoes = 4'b0000;
        tick();
        tick();
        old1 = ram[1];
        bus.botoes = 4'b0100;
        reset = 1'b0;
        tick();
        n_tests++;
        if (bus.db_estado !== 4'b0000 || bus.mem_we !== 1'b0 || bus.leds !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid: st=%b we=%b leds=%b, required 0000/0/0000",
                     bus.db_estado, bus.mem_we, bus.leds);
        end
        reset = 1'b1;
        bus.botoes = 4'b0000;
        tick();
        n_tests++;
        if (ram[1] !== old1 || bus.db_estado !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_no_write: ram1=%b st=%b, required %b/0000", ram[1], bus.db_estado, old1);
        end
    endtask

    initial begin
        reset = 1'b0;
        carga_en = 1'b0;
        carga_addr = 4'd0;
        carga_dado = 4'd0;
        bus.jogar = 1'b0;
        bus.configuracao = 2'b00;
        bus.botoes = 4'b0000;
        test_reset();
        test_demo_win();
        test_random_wrong();
        test_timeout();
        test_no_timeout_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
